// File: rtl/elevator_car_ctrl_if.sv
// elevator_car_ctrl_if: request, comparator-operand and status bus of the car controller
interface elevator_car_ctrl_if #(
    parameter int W      = 4,
    parameter int FLOORS = 16
);
    logic              req_valid;
    logic [W:1]        req_floor;
    logic              req_err;
    logic [W:1]        cur_floor;
    logic [W:1]        tgt_floor;
    logic              cmp_eq;
    logic              moving;
    logic              dir_up;
    logic              door_open;
    logic              arrive;
    logic [FLOORS-1:0] pend;
    modport master (
        output req_valid, req_floor, cmp_eq,
        input  req_err, cur_floor, tgt_floor, moving, dir_up, door_open, arrive, pend
    );
    modport slave (
        input  req_valid, req_floor, cmp_eq,
        output req_err, cur_floor, tgt_floor, moving, dir_up, door_open, arrive, pend
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: latches floor requests, picks targets by travel direction, steps the car and times the door
module elevator_car_ctrl #(
    parameter int W        = 4,
    parameter int FLOORS   = 16,
    parameter int MOVE_CYC = 8,
    parameter int DOOR_CYC = 16
) (
    input logic clk,
    input logic rst_n,
    elevator_car_ctrl_if.slave bus
);
    localparam int MW = $clog2(MOVE_CYC);
    localparam int DW = $clog2(DOOR_CYC);
    localparam logic [FLOORS-1:0] one = FLOORS'(1);
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
    state_t            state, state_n;
    logic [MW-1:0]     mcnt, mcnt_n;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [W:1]        cur_n, tgt_n, up_t, dn_t;
    logic              dir_n, up_f, dn_f, in_range, same, step, arrive_n, err_n;
    logic [FLOORS-1:0] set, clr, pend_n;
    assign bus.moving    = state == MOVE;
    assign bus.door_open = state == DOOR;
    assign step = state == MOVE && !bus.cmp_eq && mcnt == MW'(MOVE_CYC - 1);
    always_comb begin
        state_n  = state;
        mcnt_n   = mcnt;
        dcnt_n   = dcnt;
        cur_n    = bus.cur_floor;
        tgt_n    = bus.tgt_floor;
        dir_n    = bus.dir_up;
        up_f     = 1'b0;
        dn_f     = 1'b0;
        up_t     = '0;
        dn_t     = '0;
        clr      = '0;
        in_range = bus.req_valid && int'(bus.req_floor) < FLOORS;
        same     = bus.req_valid && bus.req_floor == bus.cur_floor;
        set      = (in_range && !(state == DOOR && same)) ? one << bus.req_floor : '0;
        // nearest pending floor on each side of the car
        for (int i = 0; i < FLOORS; i++) begin
            if (bus.pend[i] && i > int'(bus.cur_floor) && !up_f) begin
                up_f = 1'b1;
                up_t = W'(i);
            end
            if (bus.pend[i] && i < int'(bus.cur_floor)) begin
                dn_f = 1'b1;
                dn_t = W'(i);
            end
        end
        case (state)
            IDLE:
                if (bus.pend[bus.cur_floor]) begin
                    state_n = DOOR;
                    tgt_n   = bus.cur_floor;
                    clr     = one << bus.cur_floor;
                end else if (|bus.pend) begin
                    state_n = MOVE;
                    mcnt_n  = '0;
                    dir_n   = bus.dir_up ? up_f : !dn_f;
                    tgt_n   = dir_n ? up_t : dn_t;
                end
            MOVE:
                if (bus.cmp_eq) begin
                    state_n = DOOR;
                    clr     = one << bus.tgt_floor;
                    mcnt_n  = '0;
                end else if (step) begin
                    mcnt_n = '0;
                    cur_n  = bus.dir_up ? bus.cur_floor + 1'b1 : bus.cur_floor - 1'b1;
                end else
                    mcnt_n = mcnt + 1'b1;
            DOOR:
                if (same) dcnt_n = '0;
                else if (dcnt == DW'(DOOR_CYC - 1)) begin
                    state_n = IDLE;
                    dcnt_n  = '0;
                end else
                    dcnt_n = dcnt + 1'b1;
            default: state_n = IDLE;
        endcase
        pend_n   = (bus.pend | set) & ~clr;
        arrive_n = state_n == DOOR && state != DOOR;
        err_n    = bus.req_valid && !in_range;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mcnt          <= '0;
            dcnt          <= '0;
            bus.cur_floor <= '0;
            bus.tgt_floor <= '0;
            bus.dir_up    <= 1'b1;
            bus.pend      <= '0;
            bus.arrive    <= 1'b0;
            bus.req_err   <= 1'b0;
        end else begin
            state         <= state_n;
            mcnt          <= mcnt_n;
            dcnt          <= dcnt_n;
            bus.cur_floor <= cur_n;
            bus.tgt_floor <= tgt_n;
            bus.dir_up    <= dir_n;
            bus.pend      <= pend_n;
            bus.arrive    <= arrive_n;
            bus.req_err   <= err_n;
        end
    end
    a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
        step |-> (bus.dir_up ? int'(bus.cur_floor) < FLOORS - 1 : bus.cur_floor != '0));
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed trips with hand-computed cycle timing, FLOORS=10 MOVE_CYC=4 DOOR_CYC=6
module tb_elevator_car_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    elevator_car_ctrl_if #(.W(4), .FLOORS(10)) bus ();
    elevator_car_ctrl #(.W(4), .FLOORS(10), .MOVE_CYC(4), .DOOR_CYC(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    assign bus.cmp_eq = bus.cur_floor == bus.tgt_floor;
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic req(input int f);
        bus.req_valid = 1'b1;
        bus.req_floor = 4'(f);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask
    function automatic int st();
        return {bus.moving, bus.door_open, bus.arrive, bus.req_err};
    endfunction
    initial begin
        int cur_e;
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        repeat (2) @(negedge clk);
        check("rst_status", st(), 0);
        check("rst_cur", int'(bus.cur_floor), 0);
        check("rst_tgt", int'(bus.tgt_floor), 0);
        check("rst_dir", int'(bus.dir_up), 1);
        check("rst_pend", int'(bus.pend), 0);
        rst_n = 1'b1;
        @(negedge clk);
        // single trip 0 -> 3: moving from k=1, steps at 5/9/13, door k=14..19
        req(3);
        check("trip_pend", int'(bus.pend), 8);
        for (int k = 0; k <= 20; k++) begin
            cur_e = k < 5 ? 0 : k < 9 ? 1 : k < 13 ? 2 : 3;
            check($sformatf("trip_k%0d", k),
                  {bus.moving, bus.door_open, bus.arrive, bus.cur_floor},
                  {k >= 1 && k <= 13, k >= 14 && k <= 19, k == 14, 4'(cur_e)});
            @(negedge clk);
        end
        check("trip_tgt", int'(bus.tgt_floor), 3);
        check("trip_pend_end", int'(bus.pend), 0);
        // move down to floor 2, idle again by k=12
        req(2);
        repeat (15) @(negedge clk);
        check("to2_cur", int'(bus.cur_floor), 2);
        check("to2_dir", int'(bus.dir_up), 0);
        check("to2_idle", st(), 0);
        // same-floor request in idle: door at k=1, no motion
        req(2);
        check("same_pend", int'(bus.pend), 4);
        for (int k = 0; k <= 7; k++) begin
            check($sformatf("same_k%0d", k), st(), {1'b0, k >= 1 && k <= 6, k == 1, 1'b0});
            if (k >= 1) check($sformatf("same_pend_k%0d", k), int'(bus.pend), 0);
            @(negedge clk);
        end
        // door extension: same-floor request while door counter is 4
        req(2);
        for (int k = 0; k <= 13; k++) begin
            check($sformatf("ext_k%0d", k), st(), {1'b0, k >= 1 && k <= 11, k == 1, 1'b0});
            if (k >= 1) check($sformatf("ext_pend_k%0d", k), int'(bus.pend), 0);
            bus.req_valid = k == 5;
            bus.req_floor = 4'd2;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        // trip to 5, then 2 and 7 land during the door; up-preference serves 7 first
        req(5);
        for (int k = 0; k <= 64; k++) begin
            if (k == 14) check("dir_at5", {bus.door_open, bus.cur_floor, bus.dir_up}, {1'b1, 4'd5, 1'b1});
            if (k == 20) check("dir_pend", int'(bus.pend), 132);
            if (k == 21) check("dir_go7", {bus.moving, bus.dir_up, bus.tgt_floor}, {2'b11, 4'd7});
            if (k == 29) check("dir_cur7", int'(bus.cur_floor), 7);
            if (k == 30) check("dir_arr7", {bus.door_open, bus.arrive, bus.pend}, {2'b11, 10'd4});
            if (k == 37) check("dir_go2", {bus.moving, bus.dir_up, bus.tgt_floor}, {2'b10, 4'd2});
            if (k == 58) check("dir_arr2", {bus.door_open, bus.cur_floor, bus.pend}, {1'b1, 4'd2, 10'd0});
            if (k == 64) check("dir_idle", st(), 0);
            bus.req_valid = k == 15 || k == 16;
            bus.req_floor = k == 15 ? 4'd2 : 4'd7;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        // out-of-range floor: one error pulse, nothing else changes
        req(12);
        check("oor_err", st(), 1);
        check("oor_pend", int'(bus.pend), 0);
        @(negedge clk);
        check("oor_clear", st(), 0);
        check("oor_pend2", int'(bus.pend), 0);
        req(15);
        check("oor15_err", st(), 1);
        // top floor 9 is in range; reset lands mid-move
        req(9);
        check("top_pend", {bus.req_err, bus.pend}, {1'b0, 10'd512});
        repeat (2) @(negedge clk);
        check("top_moving", {bus.moving, bus.cur_floor, bus.tgt_floor}, {1'b1, 4'd2, 4'd9});
        rst_n = 1'b0;
        #1;
        check("arst_status", st(), 0);
        check("arst_cur", int'(bus.cur_floor), 0);
        check("arst_tgt", int'(bus.tgt_floor), 0);
        check("arst_dir", int'(bus.dir_up), 1);
        check("arst_pend", int'(bus.pend), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
